// File: rtl/clock_divisor_meter.sv
// -----------------------------------------------------------------------------
// clock_divisor_meter
//
// Measures a divided clock (sig_in) generated in the clock_in domain and
// reports its period and high time in clock_in cycles. It is the checking end
// of an upstream clock divider: for a divider with divisor D it reports
// period = D and high_time = D/2. It also flags a stable (locked) or absent
// (stopped) input.
//
// Parameters:
//   WIDTH       width of the period / high-time counters and outputs
//   TIMEOUT     longest legal period in clock_in cycles (2 .. 2^WIDTH-1)
//   SYNC_STAGES number of synchronizer flops on sig_in (>= 2)
//
// Ports:
//   clock_in    in   measurement clock
//   reset_n     in   synchronous active-low reset, sampled on posedge clock_in
//   sig_in      in   divided clock under measurement
//   period      out  clock_in cycles between the last two rising edges
//   high_time   out  clock_in cycles sig_in was high within that period
//   meas_valid  out  one-cycle pulse: period/high_time just updated
//   locked      out  the last two measurements were identical
//   stopped     out  no rising edge seen within TIMEOUT cycles
// -----------------------------------------------------------------------------
module clock_divisor_meter #(
    parameter int unsigned       WIDTH       = 28,
    parameter logic [WIDTH-1:0]  TIMEOUT     = 28'd1024,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stopped
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        WAIT_EDGE = 1'b0,   // no reference edge yet (after reset or timeout)
        MEASURE   = 1'b1    // counting from the last rising edge
    } state_e;

    // -------------------------------------------------------------------------
    // Synchronizer and rising-edge detect
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sig_d_q;
    logic                   sig_s;
    logic                   rise;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign sig_s  = sync_q[SYNC_STAGES-1];
    // Flops clear to 0, so an input already high at reset release is seen as
    // a rising edge; it becomes the reference edge of the first measurement.
    assign rise   = sig_s & ~sig_d_q;

    always_ff @(posedge clock_in) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, like real hardware.
        if (!reset_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            sig_d_q <= sig_s;
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM and result registers
    // -------------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [WIDTH-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] hi_cnt_q,     hi_cnt_d;
    logic             prev_valid_q, prev_valid_d;
    logic [WIDTH-1:0] period_q,     period_d;
    logic [WIDTH-1:0] high_time_q,  high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q,     locked_d;
    logic             stopped_q,    stopped_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block free of latches.
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_cnt_d     = hi_cnt_q;
        prev_valid_d = prev_valid_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stopped_d    = stopped_q;

        case (state_q)
            WAIT_EDGE: begin
                if (rise) begin
                    // Reference edge only: nothing to report yet. The rise
                    // cycle itself is high, so hi_cnt starts at 1.
                    state_d  = MEASURE;
                    cnt_d    = ONE;
                    hi_cnt_d = ONE;
                end else if (cnt_q != TIMEOUT) begin
                    cnt_d = cnt_q + ONE;
                end else begin
                    // Saturated: no edge for TIMEOUT cycles.
                    stopped_d = 1'b1;
                end
            end

            MEASURE: begin
                if (rise) begin
                    // A rise wins even when cnt_q == TIMEOUT, so a period of
                    // exactly TIMEOUT is reported.
                    period_d     = cnt_q;
                    high_time_d  = hi_cnt_q;
                    meas_valid_d = 1'b1;
                    locked_d     = prev_valid_q
                                   && (cnt_q    == period_q)
                                   && (hi_cnt_q == high_time_q);
                    prev_valid_d = 1'b1;
                    stopped_d    = 1'b0;
                    cnt_d        = ONE;
                    hi_cnt_d     = ONE;
                end else if (cnt_q == TIMEOUT) begin
                    // Period too long: drop lock history and wait for a
                    // fresh reference edge. period/high_time keep the last
                    // good report; cnt holds at TIMEOUT.
                    stopped_d    = 1'b1;
                    locked_d     = 1'b0;
                    prev_valid_d = 1'b0;
                    state_d      = WAIT_EDGE;
                end else begin
                    // cnt < TIMEOUT and hi_cnt <= cnt, so neither can wrap.
                    cnt_d    = cnt_q + ONE;
                    hi_cnt_d = hi_cnt_q + {{(WIDTH-1){1'b0}}, sig_s};
                end
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q      <= WAIT_EDGE;
            cnt_q        <= '0;
            hi_cnt_q     <= '0;
            prev_valid_q <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stopped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            prev_valid_q <= prev_valid_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stopped_q    <= stopped_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign stopped    = stopped_q;

endmodule

// File: tb/tb_clock_divisor_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_divisor_meter
//
// Directed stimulus for clock_divisor_meter (default parameters, TIMEOUT=1024).
// Expected reports are queued as stimulus is issued; a monitor pops and
// compares one entry every time meas_valid is seen.
// -----------------------------------------------------------------------------
module tb_clock_divisor_meter;

    logic        clock_in;
    logic        reset_n;
    logic        sig_in;
    logic [27:0] period;
    logic [27:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        stopped;

    clock_divisor_meter dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stopped    (stopped)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [27:0] period;
        logic [27:0] high;
        logic        locked;
        logic        stopped;
        int          gap;       // cycles since previous valid; 0 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_meas(input int p, input int h, input logic l,
                               input logic s, input int gap);
        exp_t e;
        e.period  = 28'(p);
        e.high    = 28'(h);
        e.locked  = l;
        e.stopped = s;
        e.gap     = gap;
        exp_q.push_back(e);
    endtask

    // Monitor / scoreboard
    int last_valid_cyc = 0;
    always @(negedge clock_in) begin
        if (meas_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("period",    period,    e.period);
                check("high_time", high_time, e.high);
                check("locked",    locked,    e.locked);
                check("stopped",   stopped,   e.stopped);
                if (e.gap != 0)
                    check("valid_spacing", cyc - last_valid_cyc, e.gap);
            end
            last_valid_cyc = cyc;
        end
    end

    // One sample of sig_in per clock_in cycle.
    task automatic tick(input logic s);
        sig_in = s;
        @(posedge clock_in);
        #1;
    endtask

    task automatic period_run(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) tick(1'b1);
            for (int i = 0; i < l; i++) tick(1'b0);
        end
    endtask

    task automatic do_reset(input logic s, input int cycles);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick(s);
        reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(sig_in);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_period"},     period,     0);
        check({tag, "_high_time"},  high_time,  0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_locked"},     locked,     0);
        check({tag, "_stopped"},    stopped,    0);
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        sig_in  = 1'b0;

        // ---- Reset state -----------------------------------------------------
        do_reset(1'b0, 2);
        check_outputs_zero("reset");

        // ---- DIVISOR=2, 10 periods ---------------------------------------------
        expect_meas(2, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) expect_meas(2, 1, 1'b1, 1'b0, 2);
        period_run(1, 1, 10);
        drain("div2_drain");
        check("div2_locked",  locked,  1);
        check("div2_stopped", stopped, 0);

        // ---- DIVISOR=5, 6 periods ----------------------------------------------
        do_reset(1'b0, 1);
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) expect_meas(5, 2, 1'b1, 1'b0, 5);
        period_run(2, 3, 6);
        drain("div5_drain");

        // ---- DIVISOR=5 -> 50 with a truncated transition period -----------------
        do_reset(1'b0, 1);
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        expect_meas(3, 2, 1'b0, 1'b0, 3);
        expect_meas(50, 25, 1'b0, 1'b0, 50);
        expect_meas(50, 25, 1'b1, 1'b0, 50);
        period_run(2, 3, 2);
        period_run(2, 1, 1);
        period_run(25, 25, 3);
        drain("div5_50_drain");

        // ---- DIVISOR=5 then hold low: timeout, then resume -----------------------
        do_reset(1'b0, 1);
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        period_run(2, 3, 4);
        drain("pre_timeout_drain");
        for (int i = 0; i < 990; i++) tick(1'b0);
        check("stopped_not_early", stopped, 0);
        for (int i = 0; i < 100 && !stopped; i++) tick(1'b0);
        check("timeout_stopped",   stopped,   1);
        check("timeout_locked",    locked,    0);
        check("timeout_period",    period,    5);
        check("timeout_high_time", high_time, 2);
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        period_run(2, 3, 3);
        drain("resume_drain");

        // ---- Period 1024 reported, 1025 times out ------------------------------
        do_reset(1'b0, 1);
        expect_meas(1024, 1, 1'b0, 1'b0, 0);
        period_run(1, 1023, 1);
        period_run(1, 1024, 1);
        tick(1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0);
        drain("p1024_drain");
        check("p1025_stopped", stopped, 1);
        check("p1025_period",  period,  1024);

        // ---- Reset mid-period while sig_in low -------------------------------
        do_reset(1'b0, 1);
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        period_run(2, 3, 2);
        tick(1'b1); tick(1'b1); tick(1'b0);
        drain("pre_reset_drain");
        do_reset(1'b0, 1);
        check_outputs_zero("mid_reset");
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        period_run(2, 3, 3);
        drain("post_reset_drain");

        // ---- Reset while sig_in high: counts as the first rise -------------
        do_reset(1'b1, 1);
        check_outputs_zero("high_reset");
        expect_meas(5, 2, 1'b0, 1'b0, 0);
        expect_meas(5, 2, 1'b1, 1'b0, 5);
        tick(1'b1); tick(1'b1);
        tick(1'b0); tick(1'b0); tick(1'b0);
        period_run(2, 3, 2);
        drain("high_reset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
